// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: MEM-stage FSM states, control-bit positions
// and the default memory-access parameters.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;
    localparam int M_MEMREAD   = 1;
    localparam int M_MEMWRITE  = 0;

    // A bubble clears both write-back control bits.
    localparam logic [1:0] WB_BUBBLE =
        ~((2'b01 << WB_REGWRITE) | (2'b01 << WB_MEMTOREG));

    localparam int          DEFAULT_TIMEOUT    = 16;
    localparam logic [31:0] DEFAULT_FAULT_DATA = 32'h0000_0000;

    function automatic logic is_mem_op(input logic [1:0] m);
        return m[M_MEMREAD] | m[M_MEMWRITE];
    endfunction

endpackage

// File: rtl/dmem_wait_counter.sv
// Clearable saturating wait counter; expired flags the last permitted BUSY cycle.
module dmem_wait_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear)
            count_next = '0;
        else if (enable && (count_reg != W'(TIMEOUT)))
            count_next = count_reg + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            count_reg <= '0;
        else
            count_reg <= count_next;
    end

    assign expired = (count_reg == W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage controller: issues word loads/stores over a req/ack handshake,
// stalls the front of the pipeline while busy and bounds each access by a timeout.
module mem_access_stage
    import mips_pkg::*;
#(
    parameter int          TIMEOUT    = DEFAULT_TIMEOUT,
    parameter logic [31:0] FAULT_DATA = DEFAULT_FAULT_DATA
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  WB_IN,
    input  logic [1:0]  M_IN,
    input  logic [31:0] ALU_resultIN,
    input  logic [31:0] Mem_WDataIN,
    input  logic [4:0]  Reg_WIDIN,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic [1:0]  WB_OUT,
    output logic [31:0] Mem_RDataOUT,
    output logic [31:0] ALU_resultOUT,
    output logic [4:0]  Reg_WIDOUT,
    output logic        mem_fault
);

    mem_state_t  state_reg;
    mem_state_t  state_next;

    logic        dmem_req_reg;
    logic        dmem_we_reg;
    logic [31:0] dmem_addr_reg;
    logic [31:0] dmem_wdata_reg;
    logic [31:0] rdata_reg;
    logic        mem_fault_reg;

    logic        mem_op;
    logic        mem_read;
    logic        mem_write;
    logic        aligned;
    logic        expired;
    logic        cnt_clear;
    logic        cnt_enable;

    assign mem_read  = M_IN[M_MEMREAD];
    assign mem_write = M_IN[M_MEMWRITE];
    assign mem_op    = is_mem_op(M_IN);
    assign aligned   = (ALU_resultIN[1:0] == 2'b00);

    assign cnt_clear  = (state_reg != BUSY);
    assign cnt_enable = (state_reg == BUSY) && !dmem_ack;

    dmem_wait_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_counter (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (!reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (mem_op && aligned) state_next = BUSY;
            BUSY:    if (dmem_ack || expired) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // While reset is held the stage behaves as an idle pass-through.
    always_comb begin
        stall  = 1'b0;
        WB_OUT = WB_IN;
        if (reset) begin
            case (state_reg)
                IDLE: begin
                    if (mem_op) begin
                        WB_OUT = WB_BUBBLE;
                        stall  = aligned;
                    end
                end
                BUSY: begin
                    WB_OUT = WB_BUBBLE;
                    stall  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A store never touches rdata_reg unless it times out; a timeout always
    // leaves FAULT_DATA behind so a faulted load writes a known value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dmem_req_reg   <= 1'b0;
            dmem_we_reg    <= 1'b0;
            dmem_addr_reg  <= '0;
            dmem_wdata_reg <= '0;
            rdata_reg      <= '0;
            mem_fault_reg  <= 1'b0;
        end else begin
            mem_fault_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (mem_op) begin
                        if (!aligned) begin
                            mem_fault_reg <= 1'b1;
                        end else begin
                            dmem_req_reg   <= 1'b1;
                            dmem_we_reg    <= mem_write & ~mem_read;
                            dmem_addr_reg  <= {ALU_resultIN[31:2], 2'b00};
                            dmem_wdata_reg <= Mem_WDataIN;
                        end
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        dmem_req_reg <= 1'b0;
                        if (!dmem_we_reg)
                            rdata_reg <= dmem_rdata;
                    end else if (expired) begin
                        dmem_req_reg  <= 1'b0;
                        rdata_reg     <= FAULT_DATA;
                        mem_fault_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dmem_req      = dmem_req_reg;
    assign dmem_we       = dmem_we_reg;
    assign dmem_addr     = dmem_addr_reg;
    assign dmem_wdata    = dmem_wdata_reg;
    assign mem_fault     = mem_fault_reg;
    assign Mem_RDataOUT  = rdata_reg;
    assign ALU_resultOUT = ALU_resultIN;
    assign Reg_WIDOUT    = Reg_WIDIN;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: idle-cycle vector table, directed
// multi-cycle sequences and randomized accesses against a transaction-level model.
module tb_mem_access_stage;

    localparam int          TO = 4;
    localparam logic [31:0] FD = 32'hBAD0_FA17;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  WB_IN;
    logic [1:0]  M_IN;
    logic [31:0] ALU_resultIN;
    logic [31:0] Mem_WDataIN;
    logic [4:0]  Reg_WIDIN;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        stall;
    logic [1:0]  WB_OUT;
    logic [31:0] Mem_RDataOUT;
    logic [31:0] ALU_resultOUT;
    logic [4:0]  Reg_WIDOUT;
    logic        mem_fault;

    mem_access_stage #(.TIMEOUT(TO), .FAULT_DATA(FD)) dut (
        .clk           (clk),
        .reset         (reset),
        .WB_IN         (WB_IN),
        .M_IN          (M_IN),
        .ALU_resultIN  (ALU_resultIN),
        .Mem_WDataIN   (Mem_WDataIN),
        .Reg_WIDIN     (Reg_WIDIN),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_rdata    (dmem_rdata),
        .dmem_ack      (dmem_ack),
        .stall         (stall),
        .WB_OUT        (WB_OUT),
        .Mem_RDataOUT  (Mem_RDataOUT),
        .ALU_resultOUT (ALU_resultOUT),
        .Reg_WIDOUT    (Reg_WIDOUT),
        .mem_fault     (mem_fault)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_rdata;   // what the MEM/WB read-data bus should currently hold

    typedef struct {
        logic [1:0]  wb;
        logic [1:0]  m;
        logic [31:0] addr;
        logic [1:0]  exp_wb;
        logic        exp_fault;
    } idle_vec_t;

    idle_vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single IDLE-cycle instruction (pass-through or misaligned), then NOP cycles
    // to observe the one-cycle fault pulse.
    task automatic run_idle(input logic [1:0] wb, input logic [1:0] m, input logic [31:0] addr,
                            input logic [1:0] exp_wb, input logic exp_fault, input string tag);
        logic [4:0] rid;
        rid          = 5'($urandom);
        WB_IN        = wb;
        M_IN         = m;
        ALU_resultIN = addr;
        Mem_WDataIN  = $urandom;
        Reg_WIDIN    = rid;
        dmem_rdata   = $urandom;
        dmem_ack     = 1'($urandom);
        #1;
        chk({tag, " stall"}, 32'(stall), 32'(0));
        chk({tag, " WB_OUT"}, 32'(WB_OUT), 32'(exp_wb));
        chk({tag, " ALU_resultOUT"}, ALU_resultOUT, addr);
        chk({tag, " Reg_WIDOUT"}, 32'(Reg_WIDOUT), 32'(rid));
        chk({tag, " Mem_RDataOUT"}, Mem_RDataOUT, model_rdata);
        step();
        M_IN     = 2'b00;
        dmem_ack = 1'b0;
        chk({tag, " dmem_req"}, 32'(dmem_req), 32'(0));
        chk({tag, " mem_fault pulse"}, 32'(mem_fault), 32'(exp_fault));
        step();
        chk({tag, " mem_fault clear"}, 32'(mem_fault), 32'(0));
        $display("txn %s: M=%b addr=%h wb_out=%b fault=%0d", tag, m, addr, exp_wb, exp_fault);
    endtask

    // Aligned access; ack raised in BUSY cycle k (k > TO means no ack in BUSY,
    // and k == TO+1 raises a stray ack in DONE that must be ignored).
    task automatic run_access(input logic [1:0] wb, input logic [1:0] m, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata, input int k,
                              input string tag);
        int          cyc;
        int          nstall;
        int          exp_stall;
        logic        timed_out;
        logic [31:0] exp_rd;
        logic [4:0]  rid;
        timed_out = (k > TO);
        exp_stall = timed_out ? TO + 1 : k + 1;
        if (timed_out)   exp_rd = FD;
        else if (m[1])   exp_rd = rdata;
        else             exp_rd = model_rdata;
        rid          = 5'($urandom);
        WB_IN        = wb;
        M_IN         = m;
        ALU_resultIN = addr;
        Mem_WDataIN  = wdata;
        Reg_WIDIN    = rid;
        dmem_rdata   = rdata;
        cyc    = 0;
        nstall = 0;
        while (cyc <= TO + 3) begin
            dmem_ack = (cyc == k);
            #1;
            if (!stall) break;
            nstall++;
            chk({tag, " WB_OUT bubble"}, 32'(WB_OUT), 32'(0));
            if (cyc == 0) begin
                chk({tag, " dmem_req idle"}, 32'(dmem_req), 32'(0));
            end else begin
                chk({tag, " dmem_req busy"}, 32'(dmem_req), 32'(1));
                chk({tag, " dmem_addr"}, dmem_addr, addr);
                chk({tag, " dmem_we"}, 32'(dmem_we), 32'(m == 2'b01));
                chk({tag, " dmem_wdata"}, dmem_wdata, wdata);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, " stall cycles"}, 32'(nstall), 32'(exp_stall));
        chk({tag, " DONE WB_OUT"}, 32'(WB_OUT), 32'(wb));
        chk({tag, " DONE Mem_RDataOUT"}, Mem_RDataOUT, exp_rd);
        chk({tag, " DONE ALU_resultOUT"}, ALU_resultOUT, addr);
        chk({tag, " DONE Reg_WIDOUT"}, 32'(Reg_WIDOUT), 32'(rid));
        chk({tag, " DONE mem_fault"}, 32'(mem_fault), 32'(timed_out));
        chk({tag, " DONE dmem_req"}, 32'(dmem_req), 32'(0));
        model_rdata = exp_rd;
        M_IN = 2'b00;
        step();
        dmem_ack = 1'b0;
        chk({tag, " after mem_fault"}, 32'(mem_fault), 32'(0));
        chk({tag, " after Mem_RDataOUT"}, Mem_RDataOUT, model_rdata);
        chk({tag, " after dmem_req"}, 32'(dmem_req), 32'(0));
        $display("txn %s: M=%b addr=%h k=%0d stall=%0d rdata_out=%h timeout=%0d",
                 tag, m, addr, k, nstall, exp_rd, timed_out);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [1:0]  r_wb;
    logic [1:0]  r_m;
    logic [31:0] r_addr;
    int          r_sel;

    initial begin
        vecs[0] = '{wb: 2'b10, m: 2'b00, addr: 32'h0000_1234, exp_wb: 2'b10, exp_fault: 1'b0};
        vecs[1] = '{wb: 2'b11, m: 2'b00, addr: 32'hFFFF_FFFF, exp_wb: 2'b11, exp_fault: 1'b0};
        vecs[2] = '{wb: 2'b01, m: 2'b00, addr: 32'h0000_0003, exp_wb: 2'b01, exp_fault: 1'b0};
        vecs[3] = '{wb: 2'b11, m: 2'b10, addr: 32'h0000_0102, exp_wb: 2'b00, exp_fault: 1'b1};
        vecs[4] = '{wb: 2'b10, m: 2'b01, addr: 32'h0000_0041, exp_wb: 2'b00, exp_fault: 1'b1};
        vecs[5] = '{wb: 2'b11, m: 2'b11, addr: 32'h8000_0103, exp_wb: 2'b00, exp_fault: 1'b1};

        reset        = 1'b0;
        WB_IN        = 2'b11;
        M_IN         = 2'b10;
        ALU_resultIN = 32'h0000_0100;
        Mem_WDataIN  = 32'h1357_9BDF;
        Reg_WIDIN    = 5'd7;
        dmem_rdata   = 32'h0;
        dmem_ack     = 1'b0;
        model_rdata  = 32'h0;
        step();
        step();
        chk("reset stall", 32'(stall), 32'(0));
        chk("reset WB_OUT", 32'(WB_OUT), 32'(2'b11));
        chk("reset dmem_req", 32'(dmem_req), 32'(0));
        chk("reset dmem_we", 32'(dmem_we), 32'(0));
        chk("reset dmem_addr", dmem_addr, 32'h0);
        chk("reset dmem_wdata", dmem_wdata, 32'h0);
        chk("reset mem_fault", 32'(mem_fault), 32'(0));
        chk("reset Mem_RDataOUT", Mem_RDataOUT, 32'h0);
        $display("txn reset: outputs at reset values");
        M_IN  = 2'b00;
        reset = 1'b1;
        step();

        for (int i = 0; i < 6; i++)
            run_idle(vecs[i].wb, vecs[i].m, vecs[i].addr, vecs[i].exp_wb, vecs[i].exp_fault,
                     $sformatf("vec%0d", i));

        run_access(2'b11, 2'b10, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 3, "load_ack3");
        run_access(2'b00, 2'b01, 32'h0000_0040, 32'hA5A5_A5A5, 32'h1111_1111, 1, "store_ack1");
        run_access(2'b11, 2'b10, 32'h0000_0200, 32'h0, 32'h2222_2222, TO + 1, "load_timeout");
        run_access(2'b11, 2'b11, 32'h0000_0204, 32'h0, 32'h3333_3333, TO, "load_ack_last");

        // Reset in the middle of an access, followed by a late ack.
        WB_IN        = 2'b11;
        M_IN         = 2'b10;
        ALU_resultIN = 32'h0000_0300;
        dmem_rdata   = 32'h7777_7777;
        dmem_ack     = 1'b0;
        step();
        chk("rstbusy dmem_req before", 32'(dmem_req), 32'(1));
        step();
        reset = 1'b0;
        #1;
        chk("rstbusy stall while reset", 32'(stall), 32'(0));
        chk("rstbusy WB_OUT while reset", 32'(WB_OUT), 32'(2'b11));
        step();
        chk("rstbusy dmem_req dropped", 32'(dmem_req), 32'(0));
        chk("rstbusy mem_fault", 32'(mem_fault), 32'(0));
        reset    = 1'b1;
        M_IN     = 2'b00;
        dmem_ack = 1'b1;
        #1;
        chk("rstbusy stall late ack", 32'(stall), 32'(0));
        step();
        dmem_ack = 1'b0;
        chk("rstbusy dmem_req late ack", 32'(dmem_req), 32'(0));
        chk("rstbusy Mem_RDataOUT", Mem_RDataOUT, 32'h0);
        chk("rstbusy mem_fault late ack", 32'(mem_fault), 32'(0));
        model_rdata = 32'h0;
        $display("txn reset_in_busy: access abandoned, late ack ignored");
        run_access(2'b10, 2'b10, 32'h0000_0400, 32'h0, 32'h4444_4444, 2, "post_reset_load");

        for (int i = 0; i < 40; i++) begin
            r_sel  = $urandom_range(0, 3);
            r_wb   = 2'($urandom);
            r_addr = $urandom;
            if (r_sel == 0) begin
                run_idle(r_wb, 2'b00, r_addr, r_wb, 1'b0, $sformatf("rnd%0d_pass", i));
            end else if (r_sel == 1) begin
                r_m = 2'($urandom_range(1, 3));
                if (r_addr[1:0] == 2'b00) r_addr[1:0] = 2'($urandom_range(1, 3));
                run_idle(r_wb, r_m, r_addr, 2'b00, 1'b1, $sformatf("rnd%0d_misal", i));
            end else begin
                r_m = 2'($urandom_range(1, 3));
                r_addr[1:0] = 2'b00;
                run_access(r_wb, r_m, r_addr, $urandom, $urandom, $urandom_range(1, TO + 1),
                           $sformatf("rnd%0d_acc", i));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
